// File: rtl/ps2_receiver_if.sv
// PS/2 receive bundle: raw PS/2 lines in, decoded byte and status strobes out.
// Latency: none (wiring only).
// Backpressure: none; the consumer must take each strobe in the cycle it fires.
interface ps2_receiver_if;
    logic       PS2Clk;
    logic       PS2Data;
    logic [7:0] Dout;
    logic       Valid;
    logic       ParityErr;
    logic       FrameErr;
    logic       Busy;

    // Receiver side: samples the lines, drives the result.
    modport master (
        input  PS2Clk,
        input  PS2Data,
        output Dout,
        output Valid,
        output ParityErr,
        output FrameErr,
        output Busy
    );

    // Line driver / byte consumer side.
    modport slave (
        output PS2Clk,
        output PS2Data,
        input  Dout,
        input  Valid,
        input  ParityErr,
        input  FrameErr,
        input  Busy
    );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 host receiver: deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop).
// Latency: strobe 3 CLK edges after the stop-bit PS2Clk fall (+FILTER_LEN with PS2_RX_FILTER_EN).
// Backpressure: none; Valid/ParityErr/FrameErr are one-cycle strobes, exactly one per frame.
module ps2_receiver #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FILTER_LEN     = 4
) (
    input  logic              CLK,
    input  logic              Resetn,
    ps2_receiver_if.master    bus
);

    localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]   TO_ONE  = TW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t         state_q,    state_d;
    logic           clk_s1_q,   clk_s1_d;
    logic           clk_s2_q,   clk_s2_d;
    logic           dat_s1_q,   dat_s1_d;
    logic           dat_s2_q,   dat_s2_d;
    logic           clk_prev_q, clk_prev_d;
    logic [3:0]     bitcnt_q,   bitcnt_d;
    logic [9:0]     shift_q,    shift_d;
    logic [TW-1:0]  to_cnt_q,   to_cnt_d;
    logic [7:0]     dout_q,     dout_d;
    logic           valid_q,    valid_d;
    logic           perr_q,     perr_d;
    logic           ferr_q,     ferr_d;
    logic           clk_lvl;
    logic           fe;

    // Two-flop synchronisers for both PS/2 lines; edge detector history.
    always_comb begin
        clk_s1_d   = bus.PS2Clk;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = bus.PS2Data;
        dat_s2_d   = dat_s1_q;
        clk_prev_d = clk_lvl;
    end

`ifdef PS2_RX_FILTER_EN
    localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

    logic       flt_q,     flt_d;
    logic [3:0] flt_cnt_q, flt_cnt_d;

    // Deglitch: filtered level flips only after FILTER_LEN consecutive differing samples.
    always_comb begin
        flt_d     = flt_q;
        flt_cnt_d = 4'd0;
        if (clk_s2_q != flt_q) begin
            if (flt_cnt_q == FLT_LAST) begin
                flt_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 4'd1;
            end
        end
    end

    // Filter state register; level resets to the idle-high line state.
    always_ff @(posedge CLK) begin
        if (!Resetn) begin
            flt_q     <= 1'b1;
            flt_cnt_q <= 4'd0;
        end else begin
            flt_q     <= flt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign clk_lvl = flt_q;
`else
    assign clk_lvl = clk_s2_q;
`endif

    assign fe = clk_prev_q & ~clk_lvl;

    // Frame FSM: strobes and Dout are registered on entry to CHECK so they are
    // visible during the CHECK cycle; the timeout strobe shows in the following IDLE cycle.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        to_cnt_d = to_cnt_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fe && !dat_s2_q) begin
                    state_d  = SHIFT;
                    bitcnt_d = 4'd0;
                    to_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (fe) begin
                    shift_d  = {dat_s2_q, shift_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    to_cnt_d = '0;
                    if (bitcnt_q == 4'd9) begin
                        // shift_q[8:1] = data, shift_q[9] = parity, dat_s2_q = stop.
                        state_d = CHECK;
                        if (!dat_s2_q) begin
                            ferr_d = 1'b1;
                        end else if (!(^shift_q[9:1])) begin
                            perr_d = 1'b1;
                        end else begin
                            dout_d  = shift_q[8:1];
                            valid_d = 1'b1;
                        end
                    end
                end else if ((to_cnt_q + TO_ONE) == TO_LAST) begin
                    // Counter reaches its terminal value with no edge: abort the frame.
                    ferr_d   = 1'b1;
                    state_d  = IDLE;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            bitcnt_q   <= 4'd0;
            shift_q    <= 10'd0;
            to_cnt_q   <= '0;
            dout_q     <= 8'h00;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            clk_prev_q <= clk_prev_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            to_cnt_q   <= to_cnt_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.Dout      = dout_q;
    assign bus.Valid     = valid_q;
    assign bus.ParityErr = perr_q;
    assign bus.FrameErr  = ferr_q;
    assign bus.Busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: good, parity-error, stop-error, timeout, reset-abort and glitch frames.
// Latency: checks strobe position relative to the last raw PS2Clk fall.
// Backpressure: n/a; strobes are counted by a negedge monitor.
module tb_ps2_receiver;

    localparam int TO = 200;
    localparam int FL = 4;
`ifdef PS2_RX_FILTER_EN
    localparam int LAT_X = FL;
`else
    localparam int LAT_X = 0;
`endif

    logic CLK    = 1'b0;
    logic Resetn = 1'b0;

    always #5 CLK = ~CLK;

    ps2_receiver_if bus ();

    ps2_receiver #(
        .TIMEOUT_CYCLES (TO),
        .FILTER_LEN     (FL)
    ) dut (
        .CLK    (CLK),
        .Resetn (Resetn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    int v_cnt = 0, p_cnt = 0, f_cnt = 0, multi_cnt = 0, busy_cnt = 0;
    int v_cyc = 0, f_cyc = 0;
    logic [7:0] v_dout = 8'h00;
    logic v_busy = 1'b0, v_prev_busy = 1'b0, prev_busy = 1'b0;
    int fall_cyc = 0;

    always @(posedge CLK) cyc++;

    // Strobe monitor sampled away from the active edge.
    always @(negedge CLK) begin
        if (bus.Valid) begin
            v_cnt++;
            v_cyc       = cyc;
            v_dout      = bus.Dout;
            v_busy      = bus.Busy;
            v_prev_busy = prev_busy;
        end
        if (bus.ParityErr) p_cnt++;
        if (bus.FrameErr) begin
            f_cnt++;
            f_cyc = cyc;
        end
        if ((int'(bus.Valid) + int'(bus.ParityErr) + int'(bus.FrameErr)) > 1) multi_cnt++;
        if (bus.Busy) busy_cnt++;
        prev_busy = bus.Busy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // Drive n bits of b (LSB first) at a 40-cycle bit period; optional 2-cycle
    // low glitch in the high phase after each real fall except the last.
    task automatic send_bits(input logic [10:0] b, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            bus.PS2Data = b[i];
            idle(10);
            bus.PS2Clk = 1'b0;
            fall_cyc   = cyc;
            idle(20);
            bus.PS2Clk = 1'b1;
            if (glitch && i < n - 1) begin
                idle(4);
                bus.PS2Clk = 1'b0;
                idle(2);
                bus.PS2Clk = 1'b1;
                idle(4);
            end else begin
                idle(10);
            end
        end
        bus.PS2Data = 1'b1;
    endtask

    int v0, p0, f0, b0;

    task automatic snap();
        v0 = v_cnt; p0 = p_cnt; f0 = f_cnt; b0 = busy_cnt;
    endtask

    initial begin
        bus.PS2Clk  = 1'b1;
        bus.PS2Data = 1'b1;
        Resetn      = 1'b0;
        idle(3);
        chk("rst_dout",  32'(bus.Dout),      32'h00);
        chk("rst_valid", 32'(bus.Valid),     32'h0);
        chk("rst_perr",  32'(bus.ParityErr), 32'h0);
        chk("rst_ferr",  32'(bus.FrameErr),  32'h0);
        chk("rst_busy",  32'(bus.Busy),      32'h0);
        Resetn = 1'b1;
        idle(5);

        // Good frame 0x1C, odd parity bit 0.
        snap();
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
        idle(20);
        chk("f1c_valid_cnt", 32'(v_cnt - v0), 32'd1);
        chk("f1c_perr_cnt",  32'(p_cnt - p0), 32'd0);
        chk("f1c_ferr_cnt",  32'(f_cnt - f0), 32'd0);
        chk("f1c_dout",      32'(v_dout),     32'h1C);
        chk("f1c_latency",   32'(v_cyc - fall_cyc), 32'(3 + LAT_X));
        chk("f1c_busy_at_valid",   32'(v_busy),      32'h0);
        chk("f1c_busy_before",     32'(v_prev_busy), 32'h1);
        chk("f1c_dout_hold",       32'(bus.Dout),    32'h1C);

        // 0xF0 with wrong parity 0.
        snap();
        send_bits(frame(8'hF0, 1'b0, 1'b1), 11, 1'b0);
        idle(20);
        chk("ff0_perr_cnt",  32'(p_cnt - p0), 32'd1);
        chk("ff0_valid_cnt", 32'(v_cnt - v0), 32'd0);
        chk("ff0_ferr_cnt",  32'(f_cnt - f0), 32'd0);
        chk("ff0_dout_kept", 32'(bus.Dout),   32'h1C);

        // 0x00 with parity 1 but stop bit 0.
        snap();
        send_bits(frame(8'h00, 1'b1, 1'b0), 11, 1'b0);
        idle(20);
        chk("stop_ferr_cnt",  32'(f_cnt - f0), 32'd1);
        chk("stop_valid_cnt", 32'(v_cnt - v0), 32'd0);
        chk("stop_perr_cnt",  32'(p_cnt - p0), 32'd0);
        chk("stop_dout_kept", 32'(bus.Dout),   32'h1C);

        // Start + 4 data bits, then the clock stays high.
        snap();
        send_bits(frame(8'h5A, 1'b1, 1'b1), 5, 1'b0);
        idle(TO + 60);
        chk("to_ferr_cnt",  32'(f_cnt - f0), 32'd1);
        chk("to_valid_cnt", 32'(v_cnt - v0), 32'd0);
        chk("to_latency",   32'(f_cyc - fall_cyc), 32'(TO + 2 + LAT_X));
        chk("to_busy",      32'(bus.Busy),   32'h0);
        snap();
        send_bits(frame(8'h5A, 1'b1, 1'b1), 11, 1'b0);
        idle(20);
        chk("f5a_valid_cnt", 32'(v_cnt - v0), 32'd1);
        chk("f5a_dout",      32'(v_dout),     32'h5A);

        // Reset after the 6th bit, then a clean 0x29 frame.
        snap();
        send_bits(frame(8'h77, 1'b0, 1'b1), 6, 1'b0);
        Resetn = 1'b0;
        idle(1);
        chk("mid_rst_dout", 32'(bus.Dout), 32'h00);
        chk("mid_rst_busy", 32'(bus.Busy), 32'h0);
        Resetn = 1'b1;
        idle(TO + 20);
        chk("mid_rst_no_strobe", 32'((v_cnt - v0) + (p_cnt - p0) + (f_cnt - f0)), 32'd0);
        snap();
        send_bits(frame(8'h29, 1'b0, 1'b1), 11, 1'b0);
        idle(20);
        chk("f29_valid_cnt", 32'(v_cnt - v0), 32'd1);
        chk("f29_dout",      32'(v_dout),     32'h29);
        chk("f29_err_cnt",   32'((p_cnt - p0) + (f_cnt - f0)), 32'd0);

        // Falls with data high in IDLE are not start bits.
        snap();
        send_bits(11'h7FF, 5, 1'b0);
        idle(TO + 20);
        chk("idle_hi_no_strobe", 32'((v_cnt - v0) + (p_cnt - p0) + (f_cnt - f0)), 32'd0);
        chk("idle_hi_no_busy",   32'(busy_cnt - b0), 32'd0);

        // 0x1C with 2-cycle low glitches in each high phase.
        snap();
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 1'b1);
        idle(TO + 40);
`ifdef PS2_RX_FILTER_EN
        chk("glitch_valid_cnt", 32'(v_cnt - v0), 32'd1);
        chk("glitch_dout",      32'(v_dout),     32'h1C);
        chk("glitch_err_cnt",   32'((p_cnt - p0) + (f_cnt - f0)), 32'd0);
`else
        chk("glitch_valid_cnt", 32'(v_cnt - v0), 32'd0);
        chk("glitch_err_seen",  32'(((p_cnt - p0) + (f_cnt - f0)) != 0), 32'd1);
`endif

        chk("strobes_exclusive", 32'(multi_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
